// File: rtl/icap_arb_pkg.sv
// Shared types and helpers for the ICAP sharing arbiter.
// rr_pick scans from a start pointer and wraps, returning the first set request bit.
package icap_arb_pkg;

  localparam int ICAP_W      = 32;
  localparam int MAX_CLIENTS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                       input logic [IDX_W-1:0]       ptr,
                                       input int                     n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && j < MAX_CLIENTS && !r.vld && req[j[IDX_W-1:0]]) begin
        r.vld = 1'b1;
        r.idx = j[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_idle_detect.sv
// Saturating idle counter for the current ICAP holder.
// The flag is the counter MSB, so it sets after 2**(CNT_W-1) idle cycles and holds.
module icap_idle_detect #(
  parameter int CNT_W = 5
) (
  input  logic icap_clk,
  input  logic icap_rst_n,
  input  logic clr,
  output logic idle_flag
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge icap_clk or negedge icap_rst_n) begin
    if (!icap_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!cnt[CNT_W-1]) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign idle_flag = cnt[CNT_W-1];

endmodule

// File: rtl/icap_share_arbiter.sv
// N-client round-robin arbiter in front of the single ICAP primitive.
// Owns grant/release handshakes, the inter-grant gap and the registered ICAP write mux.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no holder; grant the next requester when the ICAP is available
//   ST_GRANT   | one client holds the ICAP
//   ST_RELEASE | holder is asked (cli_rel) to give the ICAP up
//   ST_GAP     | GAP_CYC cycles with no grant and CSIB high before re-arbitration
module icap_share_arbiter
  import icap_arb_pkg::*;
#(
  parameter int N_CLIENTS  = 2,
  parameter int IDLE_CNT_W = 5,
  parameter int GAP_CYC    = 2
) (
  input  logic                                                icap_clk,
  input  logic                                                icap_rst_n,
  input  logic                                                icap_avail,
  input  logic [N_CLIENTS-1:0]                                cli_en,
  input  logic [N_CLIENTS-1:0]                                cli_req,
  output logic [N_CLIENTS-1:0]                                cli_gnt,
  output logic [N_CLIENTS-1:0]                                cli_rel,
  input  logic [N_CLIENTS-1:0]                                cli_intr,
  input  logic [N_CLIENTS-1:0]                                cli_busy,
  input  logic [N_CLIENTS-1:0]                                cli_csib,
  input  logic [N_CLIENTS-1:0]                                cli_rdwrb,
  input  logic [ICAP_W*N_CLIENTS-1:0]                         cli_icap_i,
  output logic                                                icap_csib,
  output logic                                                icap_rdwrb,
  output logic [ICAP_W-1:0]                                   icap_i,
  output logic [((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] grant_id,
  output logic                                                grant_vld,
  output logic                                                idle_flag
);

  localparam int ID_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  arb_state_e           state, state_nxt;
  logic [N_CLIENTS-1:0] gnt_nxt, rel_nxt;
  logic [ID_W-1:0]      id_nxt, rr_ptr, rr_nxt, pick_id;
  logic                 vld_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;

  logic [N_CLIENTS-1:0] ereq;
  logic                 holder_req, holder_intr, holder_busy, others;
  rr_pick_t             pick;

  assign ereq        = cli_req & cli_en;
  assign holder_req  = ereq[grant_id];
  assign holder_intr = cli_intr[grant_id];
  assign holder_busy = cli_busy[grant_id];
  // gnt is one-hot on the holder, so masking it off leaves only competitors
  assign others      = |(ereq & ~cli_gnt);
  assign pick        = rr_pick(MAX_CLIENTS'(ereq), IDX_W'(rr_ptr), N_CLIENTS);
  assign pick_id     = ID_W'(pick.idx);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = cli_gnt;
    rel_nxt   = cli_rel;
    id_nxt    = grant_id;
    vld_nxt   = grant_vld;
    rr_nxt    = rr_ptr;
    gap_nxt   = gap_cnt;
    unique case (state)
      ST_IDLE: begin
        if (icap_avail && pick.vld) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = N_CLIENTS'(1) << pick_id;
          vld_nxt   = 1'b1;
          id_nxt    = pick_id;
          rr_nxt    = (pick_id == ID_W'(N_CLIENTS - 1)) ? '0 : pick_id + 1'b1;
        end
      end
      ST_GRANT, ST_RELEASE: begin
        if (!holder_req) begin
          state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          gnt_nxt   = '0;
          rel_nxt   = '0;
          vld_nxt   = 1'b0;
          gap_nxt   = GAP_LD;
        end else if (state == ST_GRANT) begin
          if (N_CLIENTS > 1 && others && (holder_intr || idle_flag)) begin
            state_nxt = ST_RELEASE;
            rel_nxt   = cli_gnt;
          end
        end else if (!others && !(holder_intr || idle_flag)) begin
          state_nxt = ST_GRANT;
          rel_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nxt = ST_IDLE;
        else               gap_nxt   = gap_cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge icap_clk or negedge icap_rst_n) begin
    if (!icap_rst_n) begin
      state     <= ST_IDLE;
      cli_gnt   <= '0;
      cli_rel   <= '0;
      grant_id  <= '0;
      grant_vld <= 1'b0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cli_gnt   <= gnt_nxt;
      cli_rel   <= rel_nxt;
      grant_id  <= id_nxt;
      grant_vld <= vld_nxt;
      rr_ptr    <= rr_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

  // The mux idles on the first grant cycle and on the cycle the grant drops.
  always_ff @(posedge icap_clk or negedge icap_rst_n) begin
    if (!icap_rst_n) begin
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
    end else if (grant_vld && vld_nxt) begin
      icap_csib  <= cli_csib[grant_id];
      icap_rdwrb <= cli_rdwrb[grant_id];
      icap_i     <= cli_icap_i[int'(grant_id)*ICAP_W +: ICAP_W];
    end else begin
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
    end
  end

  logic idle_clr;
  assign idle_clr = !grant_vld || !vld_nxt || holder_busy;

  icap_idle_detect #(
    .CNT_W (IDLE_CNT_W)
  ) u_idle (
    .icap_clk   (icap_clk),
    .icap_rst_n (icap_rst_n),
    .clr        (idle_clr),
    .idle_flag  (idle_flag)
  );

endmodule

// File: tb/tb_icap_share_arbiter.sv
// Bench for icap_share_arbiter: a vector table, hand sequences for the release/reset
// cases, then randomized traffic against a behavioural model of the arbitration rules.
module tb_icap_share_arbiter;

  localparam int N    = 2;
  localparam int GAPC = 2;
  localparam int HALF = 16;
  localparam logic [31:0] D0 = 32'hA0A0_5555;
  localparam logic [31:0] D1 = 32'hB1B1_AAAA;

  logic          icap_clk = 1'b0;
  logic          icap_rst_n;
  logic          icap_avail;
  logic [N-1:0]  cli_en, cli_req, cli_gnt, cli_rel, cli_intr, cli_busy, cli_csib, cli_rdwrb;
  logic [32*N-1:0] cli_icap_i;
  logic          icap_csib, icap_rdwrb;
  logic [31:0]   icap_i;
  logic          grant_id;
  logic          grant_vld, idle_flag;

  int checks = 0;
  int errors = 0;

  icap_share_arbiter #(.N_CLIENTS(N), .IDLE_CNT_W(5), .GAP_CYC(GAPC)) dut (
    .icap_clk   (icap_clk),
    .icap_rst_n (icap_rst_n),
    .icap_avail (icap_avail),
    .cli_en     (cli_en),
    .cli_req    (cli_req),
    .cli_gnt    (cli_gnt),
    .cli_rel    (cli_rel),
    .cli_intr   (cli_intr),
    .cli_busy   (cli_busy),
    .cli_csib   (cli_csib),
    .cli_rdwrb  (cli_rdwrb),
    .cli_icap_i (cli_icap_i),
    .icap_csib  (icap_csib),
    .icap_rdwrb (icap_rdwrb),
    .icap_i     (icap_i),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld),
    .idle_flag  (idle_flag)
  );

  always #5 icap_clk = ~icap_clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [1:0] g, input logic [1:0] r, input logic v,
                                       input logic id, input logic idl, input logic cs,
                                       input logic rw, input logic [31:0] d);
    return {23'd0, g, r, v, (v ? id : 1'b0), idl, cs, rw, d};
  endfunction

  function automatic logic [63:0] obs();
    return pack(cli_gnt, cli_rel, grant_vld, grant_id, idle_flag, icap_csib, icap_rdwrb, icap_i);
  endfunction

  task automatic do_reset();
    icap_rst_n = 1'b0;
    repeat (2) @(posedge icap_clk);
    #1 icap_rst_n = 1'b1;
  endtask

  // Behavioural model: owner index (-1 = none), release flag, gap cycles left, rr pointer,
  // and a count of consecutive idle holder cycles.
  int m_owner, m_gap, m_rr, m_run;
  bit m_rel;
  logic [63:0] m_exp;

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_rr = 0; m_run = 0; m_rel = 0;
  endtask

  task automatic model_step();
    int old;
    bit flag, others, found;
    logic [N-1:0] ereq, g;
    logic cs, rw;
    logic [31:0] d;
    old  = m_owner;
    flag = (m_run >= HALF);
    ereq = cli_req & cli_en;
    if (old < 0) begin
      if (m_gap > 0) m_gap--;
      else if (icap_avail && ereq != 0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_rr + i) % N;
          if (!found && ereq[c]) begin found = 1; m_owner = c; end
        end
        m_rr = (m_owner + 1) % N;
        m_rel = 0;
      end
    end else begin
      others = (ereq & ~(2'b01 << old)) != 0;
      if (!ereq[old]) begin
        m_owner = -1; m_rel = 0; m_gap = GAPC;
      end else if (!m_rel) begin
        if (others && (cli_intr[old] || flag)) m_rel = 1;
      end else if (!others && !(cli_intr[old] || flag)) begin
        m_rel = 0;
      end
    end
    cs = 1'b1; rw = 1'b1; d = '0;
    if (old >= 0 && m_owner >= 0) begin
      cs = cli_csib[old]; rw = cli_rdwrb[old]; d = cli_icap_i[old*32 +: 32];
    end
    if (m_owner < 0 || old < 0) m_run = 0;
    else if (cli_busy[old]) m_run = 0;
    else if (m_run < HALF) m_run++;
    g = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
    m_exp = pack(g, m_rel ? g : 2'b00, m_owner >= 0, (m_owner == 1), m_run >= HALF, cs, rw, d);
  endtask

  typedef struct {
    logic avail; logic [1:0] en; logic [1:0] req; logic [1:0] csib;
    logic [1:0] e_gnt; logic e_vld; logic e_id; logic e_csib; logic e_rdwrb; logic [31:0] e_dat;
  } vec_t;
  vec_t tbl[18];

  logic [N-1:0] req_r, busy_r;
  bit rel_seen;
  int n;

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, D0};
    tbl[2]  = '{1'b1, 2'b11, 2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, D0};
    tbl[3]  = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, D0};
    tbl[4]  = '{1'b1, 2'b11, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 2'b11, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 2'b11, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 2'b11, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 2'b11, 2'b10, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, D1};
    tbl[9]  = '{1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 2'b11, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 2'b11, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, D0};
    tbl[16] = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, D0};
    tbl[17] = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

    // reset held with both clients requesting
    icap_rst_n = 1'b0;
    icap_avail = 1'b1; cli_en = 2'b11; cli_req = 2'b11; cli_intr = 2'b00; cli_busy = 2'b11;
    cli_csib = 2'b10; cli_rdwrb = 2'b10; cli_icap_i = {D1, D0};
    @(posedge icap_clk); #1;
    chk("reset_values", obs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0));
    chk("reset_grant_id", 64'(grant_id), 64'd0);
    icap_rst_n = 1'b1;

    for (int r = 0; r < 18; r++) begin
      icap_avail = tbl[r].avail; cli_en = tbl[r].en; cli_req = tbl[r].req; cli_csib = tbl[r].csib;
      @(posedge icap_clk); #1;
      chk($sformatf("vec%0d", r), obs(),
          pack(tbl[r].e_gnt, 2'b00, tbl[r].e_vld, tbl[r].e_id, 1'b0, tbl[r].e_csib,
               tbl[r].e_rdwrb, tbl[r].e_dat));
    end

    // idle-driven release: busy holder keeps the ICAP, idle holder is asked to release
    cli_req = 2'b01; cli_en = 2'b11; icap_avail = 1'b1; cli_busy = 2'b11; cli_intr = 2'b00;
    do_reset();
    @(posedge icap_clk); #1;
    chk("t3_gnt0", 64'(cli_gnt), 64'(2'b01));
    cli_req = 2'b11;
    rel_seen = 0;
    repeat (20) begin
      @(posedge icap_clk); #1;
      if (cli_rel != 2'b00) rel_seen = 1;
    end
    chk("t3_no_rel_while_busy", 64'(rel_seen), 64'd0);
    cli_busy = 2'b10;
    for (int k = 1; k <= 16; k++) begin
      @(posedge icap_clk); #1;
      if (k == 15) chk("t3_idle_pre", 64'(idle_flag), 64'd0);
      if (k == 16) chk("t3_idle_set_no_rel", 64'({idle_flag, cli_rel}), 64'({1'b1, 2'b00}));
    end
    @(posedge icap_clk); #1;
    chk("t3_rel", 64'({cli_rel, cli_gnt}), 64'({2'b01, 2'b01}));
    cli_req = 2'b10;
    @(posedge icap_clk); #1;
    chk("t3_drop", 64'({cli_gnt, cli_rel, idle_flag, icap_csib}), 64'({2'b00, 2'b00, 1'b0, 1'b1}));
    n = 0;
    while (cli_gnt != 2'b10 && n < 10) begin
      @(posedge icap_clk); #1;
      n++;
    end
    chk("t3_handover_cycles", 64'(n), 64'd3);
    chk("t3_gnt1", 64'(cli_gnt), 64'(2'b10));

    // async reset in RELEASE; arbitration restarts from client 0
    cli_req = 2'b11; cli_intr = 2'b01; cli_busy = 2'b11;
    do_reset();
    @(posedge icap_clk); #1;
    chk("t6_gnt0", 64'(cli_gnt), 64'(2'b01));
    @(posedge icap_clk); #1;
    chk("t6_rel", 64'({cli_rel, cli_gnt}), 64'({2'b01, 2'b01}));
    icap_rst_n = 1'b0;
    #1;
    chk("t6_async_reset", obs(), pack(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0));
    cli_intr = 2'b00;
    #1 icap_rst_n = 1'b1;
    @(posedge icap_clk); #1;
    chk("t6_restart_rr0", 64'(cli_gnt), 64'(2'b01));

    // randomized traffic against the model
    cli_req = 2'b00; cli_busy = 2'b00; cli_intr = 2'b00;
    do_reset();
    model_reset();
    req_r = 2'b00; busy_r = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(29) == 0) req_r[k] = ~req_r[k];
        if ($urandom_range(9) == 0) busy_r[k] = ~busy_r[k];
        cli_en[k]   = ($urandom_range(63) != 0);
        cli_intr[k] = ($urandom_range(11) == 0);
      end
      cli_req    = req_r;
      cli_busy   = busy_r;
      icap_avail = ($urandom_range(7) != 0);
      cli_csib   = 2'($urandom);
      cli_rdwrb  = 2'($urandom);
      cli_icap_i = {$urandom, $urandom};
      model_step();
      @(posedge icap_clk); #1;
      chk($sformatf("rand%0d", c), obs(), m_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
